// File: rtl/move_command_tx_if.sv
// Handshake and serial-output bundle between the path-math block and move_command_tx.
interface move_command_tx_if;
    logic        start;
    logic [11:0] move_command;
    logic        tx_out;
    logic        busy;
    logic        sent;

    modport master (output start, move_command, input tx_out, busy, sent);
    modport slave  (input start, move_command, output tx_out, busy, sent);
endinterface

// File: rtl/move_command_tx.sv
// Serial move-command transmitter: header, gap, 12 data bits LSB first, stop; frame repeated REPEATS times.
// Define MOVE_TX_PARITY_EN to append an even-parity bit period after the data bits.
module move_command_tx #(
    parameter int BIT_CYCLES = 2700,
    parameter int REPEATS    = 3
) (
    input  logic             clock,
    input  logic             reset,
    move_command_tx_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for start
    // HEADER | line high for 4 bit periods
    // GAP    | line low for 1 bit period
    // DATA   | 12 command bits, LSB first
    // PARITY | even parity of the command (MOVE_TX_PARITY_EN only)
    // STOP   | line low for 2 bit periods, then next frame or FINISH
    // FINISH | one-cycle sent pulse
    localparam int              CNT_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [2:0]       LAST_REP = 3'(REPEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        GAP,
        DATA,
`ifdef MOVE_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        FINISH
    } state_t;

    state_t           state;
    logic [11:0]      cmd;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;
    logic [2:0]       rep_cnt;
    logic             tx_q;
    logic             busy_q;
    logic             sent_q;
    logic             period_end;
    logic [3:0]       next_idx;

    assign period_end  = (bit_cnt == LAST_CNT);
    assign next_idx    = bit_idx + 4'd1;
    assign bus.tx_out  = tx_q;
    assign bus.busy    = busy_q;
    assign bus.sent    = sent_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cmd     <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            // The period counter free-runs across state boundaries so no cycles are lost.
            if (state != IDLE && state != FINISH)
                bit_cnt <= period_end ? '0 : bit_cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cmd     <= bus.move_command;
                        rep_cnt <= '0;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= HEADER;
                    end
                end
                HEADER: begin
                    if (period_end) begin
                        if (bit_idx == 4'd3) begin
                            bit_idx <= '0;
                            tx_q    <= 1'b0;
                            state   <= GAP;
                        end else begin
                            bit_idx <= next_idx;
                        end
                    end
                end
                GAP: begin
                    if (period_end) begin
                        bit_idx <= '0;
                        tx_q    <= cmd[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (period_end) begin
                        if (bit_idx == 4'd11) begin
                            bit_idx <= '0;
`ifdef MOVE_TX_PARITY_EN
                            tx_q    <= ^cmd;
                            state   <= PARITY;
`else
                            tx_q    <= 1'b0;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= next_idx;
                            tx_q    <= cmd[next_idx];
                        end
                    end
                end
`ifdef MOVE_TX_PARITY_EN
                PARITY: begin
                    if (period_end) begin
                        tx_q  <= 1'b0;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (period_end) begin
                        if (bit_idx == 4'd1) begin
                            bit_idx <= '0;
                            rep_cnt <= rep_cnt + 3'd1;
                            if (rep_cnt == LAST_REP) begin
                                tx_q   <= 1'b0;
                                busy_q <= 1'b0;
                                sent_q <= 1'b1;
                                state  <= FINISH;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= HEADER;
                            end
                        end else begin
                            bit_idx <= next_idx;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_command_tx.sv
// Self-checking bench for move_command_tx: per-cycle waveform scoreboard driven by a vector table plus corner sequences.
module tb_move_command_tx;
    localparam int BC = 4;

    typedef struct packed {
        logic tx;
        logic busy;
        logic sent;
    } obs_t;

    typedef struct {
        logic [11:0] cmd;
        logic        par;
    } vec_t;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;
    obs_t q[$];
    vec_t vec[7];

    move_command_tx_if bus ();
    move_command_tx_if bus1 ();

    move_command_tx #(.BIT_CYCLES(BC), .REPEATS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    move_command_tx #(.BIT_CYCLES(BC), .REPEATS(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t obs(input int sel);
        obs_t o;
        if (sel == 1) o = '{tx: bus1.tx_out, busy: bus1.busy, sent: bus1.sent};
        else          o = '{tx: bus.tx_out,  busy: bus.busy,  sent: bus.sent};
        return o;
    endfunction

    task automatic check3(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got tx/busy/sent=%b required %b", name, act, exp);
    endtask

    task automatic set_start(input int sel, input logic v, input logic [11:0] c);
        if (sel == 1) begin
            bus1.start = v;
            bus1.move_command = c;
        end else begin
            bus.start = v;
            bus.move_command = c;
        end
    endtask

    task automatic push_n(input int n, input logic tx, input logic busy, input logic sent);
        obs_t o;
        o = '{tx: tx, busy: busy, sent: sent};
        for (int k = 0; k < n; k++) q.push_back(o);
    endtask

    // Expected line/busy/sent per cycle, starting with the first tx_out=1 cycle and ending with FINISH.
    task automatic expect_cmd(input logic [11:0] c, input logic par, input int reps);
        for (int r = 0; r < reps; r++) begin
            push_n(4 * BC, 1'b1, 1'b1, 1'b0);
            push_n(BC, 1'b0, 1'b1, 1'b0);
            for (int b = 0; b < 12; b++) push_n(BC, c[b], 1'b1, 1'b0);
`ifdef MOVE_TX_PARITY_EN
            push_n(BC, par, 1'b1, 1'b0);
`endif
            push_n(2 * BC, 1'b0, 1'b1, 1'b0);
        end
        push_n(1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic start_pulse(input int sel, input logic [11:0] c);
        @(negedge clock);
        set_start(sel, 1'b1, c);
        @(negedge clock);
        set_start(sel, 1'b0, 12'h000);
    endtask

    // Pops one expected entry per cycle; optionally raises start at inj_at for inj_len cycles, or stops early.
    task automatic check_queue(input int sel, input string tag, input int inj_at, input int inj_len,
                               input logic [11:0] inj_cmd, input int stop_at);
        int   idx;
        obs_t e;
        idx = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            check3($sformatf("%s[%0d]", tag, idx), obs(sel), e);
            if (idx == inj_at) set_start(sel, 1'b1, inj_cmd);
            if (idx == inj_at + inj_len) set_start(sel, 1'b0, inj_cmd);
            if (idx == stop_at || q.size() == 0) break;
            @(negedge clock);
            idx++;
        end
        q.delete();
    endtask

    initial begin
        vec[0] = '{cmd: 12'hA85, par: 1'b1};
        vec[1] = '{cmd: 12'h000, par: 1'b0};
        vec[2] = '{cmd: 12'hFFF, par: 1'b0};
        vec[3] = '{cmd: 12'h001, par: 1'b1};
        vec[4] = '{cmd: 12'h800, par: 1'b1};
        vec[5] = '{cmd: 12'h555, par: 1'b0};
        vec[6] = '{cmd: 12'h7FF, par: 1'b1};

        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        set_start(0, 1'b0, 12'h000);
        set_start(1, 1'b0, 12'h000);
        repeat (2) @(negedge clock);
        check3("reset_state", obs(0), 3'b000);
        check3("reset_state_r1", obs(1), 3'b000);
        reset = 1'b0;
        @(negedge clock);
        check3("idle_after_reset", obs(0), 3'b000);

        for (int i = 0; i < 7; i++) begin
            expect_cmd(vec[i].cmd, vec[i].par, 2);
            start_pulse(0, vec[i].cmd);
            check_queue(0, $sformatf("vec%0d", i), -1, 1, 12'h000, -1);
            @(negedge clock);
            check3($sformatf("vec%0d_idle", i), obs(0), 3'b000);
        end

        // start with a different command mid-transmission is ignored
        expect_cmd(12'hA85, 1'b1, 2);
        start_pulse(0, 12'hA85);
        check_queue(0, "ignore_mid", 30, 1, 12'hFFF, -1);

        // start in the FINISH cycle is ignored, start in the following IDLE cycle is taken
        set_start(0, 1'b1, 12'hFFF);
        @(negedge clock);
        check3("finish_start_idle", obs(0), 3'b000);
        set_start(0, 1'b1, 12'h001);
        expect_cmd(12'h001, 1'b1, 2);
        @(negedge clock);
        set_start(0, 1'b0, 12'h000);
        check_queue(0, "after_finish", -1, 1, 12'h000, -1);
        @(negedge clock);
        check3("after_finish_idle", obs(0), 3'b000);

        // reset in the middle of DATA aborts at once with no sent pulse
        expect_cmd(12'hA85, 1'b1, 2);
        start_pulse(0, 12'hA85);
        check_queue(0, "pre_reset", -1, 1, 12'h000, 40);
        reset = 1'b1;
        #1;
        check3("reset_async", obs(0), 3'b000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check3($sformatf("reset_hold%0d", k), obs(0), 3'b000);
        end
        reset = 1'b0;
        @(negedge clock);
        check3("post_reset_idle", obs(0), 3'b000);
        expect_cmd(12'h000, 1'b0, 2);
        start_pulse(0, 12'h000);
        check_queue(0, "post_reset", -1, 1, 12'h000, -1);

        // single-repeat instance with start held for three cycles
        expect_cmd(12'h3C5, 1'b0, 1);
        @(negedge clock);
        set_start(1, 1'b1, 12'h3C5);
        @(negedge clock);
        check_queue(1, "rep1_hold", 0, 2, 12'h3C5, -1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check3($sformatf("rep1_idle%0d", k), obs(1), 3'b000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
